// File: rtl/tron_compositor.sv
// Per-pixel trail/sprite compositor with a once-per-frame head-point collision prober.
// The framebuffer port is shared: probe reads take it over only during vertical blanking.
module tron_compositor #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned ADDR_W       = 19,
  parameter logic [3:0]  TRAIL_EMPTY  = 4'h8,
  parameter logic [3:0]  SPRITE_KEY   = 4'hF,
  parameter int unsigned X_BIAS       = 16,
  parameter int unsigned HEAD_OFS     = 14,
  parameter int unsigned SIDE_OFS     = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_frame_clk,
  input  logic [9:0]               i_draw_x,
  input  logic [9:0]               i_draw_y,
  input  logic [3:0]               i_sprite_in,
  input  logic [10*NUM_PLAYERS-1:0] i_bike_x,
  input  logic [10*NUM_PLAYERS-1:0] i_bike_y,
  input  logic [2*NUM_PLAYERS-1:0] i_bike_dir,
  input  logic [NUM_PLAYERS-1:0]   i_alive,
  input  logic                     i_crash_clr,
  output logic [ADDR_W-1:0]        o_fb_rd_addr,
  input  logic [15:0]              i_fb_rd_data,
  output logic [3:0]               o_color_enum,
  output logic [NUM_PLAYERS-1:0]   o_crash,
  output logic                     o_probe_done,
  output logic                     o_busy
);

  localparam int unsigned WPL   = H_RES / PIX_PER_WORD;
  localparam int unsigned BPP   = 16 / PIX_PER_WORD;
  localparam int unsigned SEL_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_PLAYERS);

  localparam logic signed [11:0] HEAD = 12'(HEAD_OFS);
  localparam logic signed [11:0] SIDE = 12'(SIDE_OFS);
  localparam logic signed [11:0] BIAS = 12'(X_BIAS);

  typedef enum logic [2:0] {StIdle, StWaitBlank, StIssue, StCheck, StDone} state_e;

  function automatic logic [3:0] f_nib(input logic [15:0] d, input logic [SEL_W-1:0] s);
    logic [3:0] n;
    n = d[3:0];
    for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
      if (32'(s) == k) n = d[k*BPP +: 4];
    end
    return n;
  endfunction

  state_e                    r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_idx, w_idx_nxt;
  logic                      r_fc, r_fc_edge, r_pending, w_pending_nxt;
  logic                      w_req, w_latch, w_adv, w_vblank;
  logic [10*NUM_PLAYERS-1:0] r_bx, r_by;
  logic [2*NUM_PLAYERS-1:0]  r_dir;
  logic [NUM_PLAYERS-1:0]    r_alive, r_crash, w_crash_set;
  logic [ADDR_W-1:0]         r_addr;
  logic [SEL_W-1:0]          r_psel;
  logic                      r_poff;

  logic [SEL_W-1:0]          r_sel1, r_sel2;
  logic [3:0]                r_spr1, r_spr2, r_color;
  logic                      r_blank1, r_blank2;

  logic [ADDR_W-1:0]         w_pix_addr, w_probe_addr;
  logic [SEL_W-1:0]          w_pix_sel, w_probe_sel;
  logic                      w_pix_blank, w_probe_off, w_probe_rd;
  logic [9:0]                w_bx, w_by;
  logic [1:0]                w_dir;
  logic signed [11:0]        w_ox, w_oy, w_px, w_py;

  assign w_pix_addr  = ADDR_W'(32'(i_draw_x) / PIX_PER_WORD + 32'(i_draw_y) * WPL);
  assign w_pix_sel   = SEL_W'(32'(i_draw_x) % PIX_PER_WORD);
  assign w_pix_blank = (32'(i_draw_x) >= H_RES) || (32'(i_draw_y) >= V_RES);
  assign w_vblank    = 32'(i_draw_y) >= V_RES;
  assign w_req       = r_fc_edge | r_pending;

  // Geometry is evaluated for the player the FSM will hold next, so the address
  // is already registered during ISSUE and the RAM word lands in CHECK.
  always_comb begin
    w_bx  = r_bx[int'(w_idx_nxt)*10 +: 10];
    w_by  = r_by[int'(w_idx_nxt)*10 +: 10];
    w_dir = r_dir[int'(w_idx_nxt)*2 +: 2];
    w_ox  = SIDE;
    w_oy  = SIDE;
    unique case (w_dir)
      2'b00: begin w_ox = SIDE;  w_oy = -HEAD; end
      2'b01: begin w_ox = SIDE;  w_oy = HEAD;  end
      2'b10: begin w_ox = -HEAD; w_oy = SIDE;  end
      2'b11: begin w_ox = HEAD;  w_oy = SIDE;  end
    endcase
    w_px = $signed({2'b00, w_bx}) + BIAS + w_ox;
    w_py = $signed({2'b00, w_by}) + w_oy;
  end

  assign w_probe_off  = w_px[11] | w_py[11] | (32'($unsigned(w_px)) >= H_RES) |
                        (32'($unsigned(w_py)) >= V_RES);
  assign w_probe_addr = ADDR_W'(32'($unsigned(w_px)) / PIX_PER_WORD +
                                32'($unsigned(w_py)) * WPL);
  assign w_probe_sel  = SEL_W'(32'($unsigned(w_px)) % PIX_PER_WORD);
  assign w_probe_rd   = (w_state_nxt == StIssue) && r_alive[w_idx_nxt] && !w_probe_off;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pending_nxt = r_pending;
    w_crash_set   = '0;
    w_latch       = 1'b0;
    w_adv         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_state_nxt = StWaitBlank;
          w_idx_nxt   = '0;
          w_latch     = 1'b1;
        end
      end
      StWaitBlank: if (w_vblank) w_state_nxt = StIssue;
      StIssue: begin
        if (!r_alive[r_idx]) begin
          w_adv = 1'b1;
        end else if (r_poff) begin
          w_crash_set[r_idx] = 1'b1;
          w_adv              = 1'b1;
        end else begin
          w_state_nxt = StCheck;
        end
      end
      StCheck: begin
        if (f_nib(i_fb_rd_data, r_psel) != TRAIL_EMPTY) w_crash_set[r_idx] = 1'b1;
        w_adv = 1'b1;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (w_adv) begin
      if (r_idx == IDX_W'(NUM_PLAYERS - 1)) begin
        w_state_nxt = StDone;
      end else begin
        w_idx_nxt   = r_idx + IDX_W'(1);
        w_state_nxt = w_vblank ? StIssue : StWaitBlank;
      end
    end
    if (r_state == StIdle) w_pending_nxt = 1'b0;
    else if (r_fc_edge)    w_pending_nxt = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_fc      <= 1'b0;
      r_fc_edge <= 1'b0;
      r_pending <= 1'b0;
      r_bx      <= '0;
      r_by      <= '0;
      r_dir     <= '0;
      r_alive   <= '0;
      r_crash   <= '0;
      r_psel    <= '0;
      r_poff    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_fc      <= i_frame_clk;
      r_fc_edge <= i_frame_clk & ~r_fc;
      r_pending <= w_pending_nxt;
      if (w_latch) begin
        r_bx    <= i_bike_x;
        r_by    <= i_bike_y;
        r_dir   <= i_bike_dir;
        r_alive <= i_alive;
      end
      // A same-cycle set overrides the clear.
      r_crash <= (i_crash_clr ? '0 : r_crash) | w_crash_set;
      if (w_state_nxt == StIssue) begin
        r_psel <= w_probe_sel;
        r_poff <= w_probe_off;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr   <= '0;
      r_sel1   <= '0;
      r_sel2   <= '0;
      r_spr1   <= '0;
      r_spr2   <= '0;
      r_blank1 <= 1'b1;
      r_blank2 <= 1'b1;
      r_color  <= '0;
    end else begin
      r_addr   <= w_probe_rd ? w_probe_addr : w_pix_addr;
      r_sel1   <= w_pix_sel;
      r_sel2   <= r_sel1;
      r_spr1   <= i_sprite_in;
      r_spr2   <= r_spr1;
      r_blank1 <= w_pix_blank;
      r_blank2 <= r_blank1;
      r_color  <= r_blank2 ? 4'h0 :
                  (r_spr2 != SPRITE_KEY) ? r_spr2 : f_nib(i_fb_rd_data, r_sel2);
    end
  end

  assign o_fb_rd_addr = r_addr;
  assign o_color_enum = r_color;
  assign o_crash      = r_crash;
  assign o_probe_done = (r_state == StDone);
  assign o_busy       = (r_state == StWaitBlank) || (r_state == StIssue) ||
                        (r_state == StCheck);

endmodule

// File: tb/tb_tron_compositor.sv
// Bench for tron_compositor: pixel vector table, random pixel stream, directed and
// random probe passes against an arithmetic reference model and a sparse RAM model.
module tb_tron_compositor;

  logic        clk, rst, fc, clr;
  logic [9:0]  draw_x, draw_y;
  logic [3:0]  spr;
  logic [19:0] bike_x, bike_y;
  logic [3:0]  bike_dir;
  logic [1:0]  alive;
  logic [18:0] fb_rd_addr;
  logic [15:0] fb_rd_data;
  logic [3:0]  color;
  logic [1:0]  crash;
  logic        probe_done, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] fb_over [int];
  logic [18:0] addr_log [$];

  tron_compositor dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_frame_clk  (fc),
    .i_draw_x     (draw_x),
    .i_draw_y     (draw_y),
    .i_sprite_in  (spr),
    .i_bike_x     (bike_x),
    .i_bike_y     (bike_y),
    .i_bike_dir   (bike_dir),
    .i_alive      (alive),
    .i_crash_clr  (clr),
    .o_fb_rd_addr (fb_rd_addr),
    .i_fb_rd_data (fb_rd_data),
    .o_color_enum (color),
    .o_crash      (crash),
    .o_probe_done (probe_done),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Sparse framebuffer: a few fixed words, otherwise a hash with many empty pixels.
  function automatic logic [15:0] fb_word(input logic [18:0] a);
    logic [31:0] h;
    logic [15:0] w;
    if (fb_over.exists(int'(a))) return fb_over[int'(a)];
    h = {13'b0, a} * 32'h9E3779B1;
    h = h ^ (h >> 15);
    for (int k = 0; k < 4; k++) w[4*k +: 4] = h[k] ? 4'h8 : h[8+4*k +: 4];
    return w;
  endfunction

  always @(posedge clk) fb_rd_data <= fb_word(fb_rd_addr);

  function automatic logic [3:0] ref_color(input int x, input int y, input logic [3:0] s);
    logic [15:0] w;
    if (x >= 640 || y >= 480) return 4'h0;
    if (s != 4'hF) return s;
    w = fb_word(19'(x / 2 + y * 320));
    return w[(x % 2) * 8 +: 4];
  endfunction

  // Returns cycles from blanking start through the DONE cycle, minus the DONE cycle.
  function automatic int probe_pass(input logic [19:0] bx, input logic [19:0] by,
                                    input logic [3:0] dir, input logic [1:0] alv,
                                    input logic [1:0] cin, output logic [1:0] cout);
    int cyc, x, y, ox, oy, px, py;
    logic [15:0] w;
    logic [1:0] d;
    cyc  = 1;
    cout = cin;
    for (int p = 0; p < 2; p++) begin
      if (!alv[p]) begin
        cyc += 1;
      end else begin
        x = int'(bx[10*p +: 10]);
        y = int'(by[10*p +: 10]);
        d = dir[2*p +: 2];
        case (d)
          2'b00:   begin ox = 3;   oy = -14; end
          2'b01:   begin ox = 3;   oy = 14;  end
          2'b10:   begin ox = -14; oy = 3;   end
          default: begin ox = 14;  oy = 3;   end
        endcase
        px = x + 16 + ox;
        py = y + oy;
        if (px < 0 || px >= 640 || py < 0 || py >= 480) begin
          cout[p] = 1'b1;
          cyc += 1;
        end else begin
          w = fb_word(19'(px / 2 + py * 320));
          if (w[(px % 2) * 8 +: 4] != 4'h8) cout[p] = 1'b1;
          cyc += 2;
        end
      end
    end
    return cyc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input string name);
    int k;
    k = 0;
    while (!busy && k < 6) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(busy), 1);
  endtask

  task automatic start_pass();
    @(negedge clk); fc = 1'b1;
    @(negedge clk); fc = 1'b0;
    wait_busy("busy_rise");
  endtask

  task automatic wait_done(output int edges);
    int seen;
    seen  = 0;
    edges = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(posedge clk); #1;
      edges++;
      addr_log.push_back(fb_rd_addr);
      if (probe_done) seen = 1;
    end
    check("probe_done_seen", 32'(seen), 1);
    if (seen != 0) begin
      check("busy_low_at_done", 32'(busy), 0);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(probe_done), 0);
    end
    @(negedge clk); draw_y = 10'd100;
  endtask

  task automatic finish_pass(output int edges);
    @(negedge clk); draw_y = 10'd500;
    addr_log.delete();
    wait_done(edges);
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  s;
    logic [18:0] addr;
    logic [3:0]  col;
  } pix_vec_t;

  pix_vec_t   vecs [8];
  logic [3:0] exp_q [$];
  logic [1:0] model_crash, next_crash;
  int         e, exp_e, hits, seen_busy;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clk = 0; rst = 1; fc = 0; clr = 0;
    draw_x = 0; draw_y = 10'd500; spr = 4'hF;
    bike_x = '0; bike_y = '0; bike_dir = '0; alive = '0;
    fb_over[642]    = 16'h0B03;
    fb_over[59579]  = 16'h0388;
    fb_over[100639] = 16'h8888;
    vecs[0] = '{10'd5,   10'd2,   4'hF, 19'd642,    4'hB};
    vecs[1] = '{10'd4,   10'd2,   4'hF, 19'd642,    4'h3};
    vecs[2] = '{10'd5,   10'd2,   4'h2, 19'd642,    4'h2};
    vecs[3] = '{10'd5,   10'd490, 4'hF, 19'd156802, 4'h0};
    vecs[4] = '{10'd645, 10'd10,  4'hF, 19'd3522,   4'h0};
    vecs[5] = '{10'd639, 10'd479, 4'h7, 19'd153599, 4'h7};
    vecs[6] = '{10'd640, 10'd479, 4'h7, 19'd153600, 4'h0};
    vecs[7] = '{10'd0,   10'd480, 4'h5, 19'd153600, 4'h0};

    repeat (3) @(negedge clk);
    check("rst_addr", 32'(fb_rd_addr), 0);
    check("rst_color", 32'(color), 0);
    check("rst_crash", 32'(crash), 0);
    check("rst_done", 32'(probe_done), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      draw_x = vecs[i].x; draw_y = vecs[i].y; spr = vecs[i].s;
      @(posedge clk); #1;
      check("pix_addr", 32'(fb_rd_addr), 32'(vecs[i].addr));
      @(negedge clk);
      draw_x = 0; draw_y = 10'd500; spr = 4'hF;
      @(posedge clk); @(posedge clk); #1;
      check("pix_color", 32'(color), 32'(vecs[i].col));
    end

    for (int i = 0; i < 152; i++) begin
      @(negedge clk);
      if (i < 150) begin
        draw_x = 10'($urandom_range(0, 700));
        draw_y = 10'($urandom_range(0, 520));
        spr    = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
        exp_q.push_back(ref_color(int'(draw_x), int'(draw_y), spr));
      end
      @(posedge clk); #1;
      if (i >= 2) check("rand_color", 32'(color), 32'(exp_q.pop_front()));
    end

    // Player 0 hits a trail, player 1 reads empty arena.
    @(negedge clk);
    draw_x = 0; draw_y = 10'd100; spr = 4'hF;
    bike_x = {10'd300, 10'd100}; bike_y = {10'd300, 10'd200};
    bike_dir = {2'b01, 2'b00}; alive = 2'b11;
    start_pass();
    finish_pass(e);
    check("a_cycles", 32'(e), 5);
    check("a_crash", 32'(crash), 32'(2'b01));
    hits = 0;
    foreach (addr_log[k]) if (addr_log[k] == 19'd59579 || addr_log[k] == 19'd100639) hits++;
    check("a_probe_addrs", 32'(hits), 2);

    // Dead player 0 skipped, player 1 off the right edge.
    bike_x = {10'd630, 10'd0}; bike_y = {10'd200, 10'd0};
    bike_dir = {2'b11, 2'b00}; alive = 2'b10;
    start_pass();
    finish_pass(e);
    check("b_cycles", 32'(e), 3);
    check("b_crash", 32'(crash), 32'(2'b11));
    hits = 0;
    foreach (addr_log[k]) if (addr_log[k] != 19'd160000) hits++;
    check("b_no_probe_read", 32'(hits), 0);

    // Edge while busy queues a second pass; clear coincides with a set in it.
    bike_x = {10'd300, 10'd100}; bike_y = {10'd300, 10'd200};
    bike_dir = {2'b01, 2'b00}; alive = 2'b11;
    start_pass();
    @(negedge clk); fc = 1'b1;
    @(negedge clk); fc = 1'b0;
    finish_pass(e);
    check("c_cycles", 32'(e), 5);
    check("c_crash_pass1", 32'(crash), 32'(2'b11));
    wait_busy("c_pending_pass");
    draw_y = 10'd500;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    check("c_set_beats_clr", 32'(crash), 32'(2'b01));
    @(negedge clk); clr = 1'b0;
    wait_done(e);
    check("c_crash_pass2", 32'(crash), 32'(2'b01));

    model_crash = crash;
    for (int it = 0; it < 20; it++) begin
      if (it % 2 == 0) begin
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_crash = 2'b00;
        check("r_clr", 32'(crash), 0);
      end
      bike_x   = {10'($urandom_range(0, 660)), 10'($urandom_range(0, 660))};
      bike_y   = {10'($urandom_range(0, 499)), 10'($urandom_range(0, 499))};
      bike_dir = 4'($urandom);
      alive    = 2'($urandom);
      exp_e = probe_pass(bike_x, bike_y, bike_dir, alive, model_crash, next_crash);
      start_pass();
      bike_x = 20'($urandom); bike_y = 20'($urandom);
      bike_dir = 4'($urandom); alive = 2'($urandom);
      finish_pass(e);
      check("r_cycles", 32'(e), 32'(exp_e));
      check("r_crash", 32'(crash), 32'(next_crash));
      model_crash = next_crash;
    end

    // Reset while in CHECK with both flags set and a pass pending.
    bike_x = {10'd630, 10'd100}; bike_y = {10'd200, 10'd200};
    bike_dir = {2'b11, 2'b00}; alive = 2'b11;
    start_pass();
    finish_pass(e);
    check("d_cycles", 32'(e), 4);
    check("d_crash", 32'(crash), 32'(2'b11));
    start_pass();
    @(negedge clk); fc = 1'b1;
    @(negedge clk); fc = 1'b0; draw_y = 10'd500;
    @(posedge clk);
    @(posedge clk); #1;
    check("d_pre_reset_crash", 32'(crash), 32'(2'b11));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("d_rst_crash", 32'(crash), 0);
    check("d_rst_busy", 32'(busy), 0);
    check("d_rst_color", 32'(color), 0);
    check("d_rst_addr", 32'(fb_rd_addr), 0);
    check("d_rst_done", 32'(probe_done), 0);
    @(negedge clk); rst = 1'b0; draw_y = 10'd100;
    seen_busy = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    check("d_pending_cleared", 32'(seen_busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
